// File: rtl/round_robin_fifo_distributor_pkg.sv
// Shared constants and helpers for the round-robin FIFO distributor.
package round_robin_fifo_distributor_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam logic [CH_W-1:0] CH_A = 2'd0;
  localparam logic [CH_W-1:0] CH_B = 2'd1;
  localparam logic [CH_W-1:0] CH_C = 2'd2;
  localparam logic [CH_W-1:0] CH_D = 2'd3;

  // Smallest r with (1 << r) >= value; sizes FIFO pointers and counts.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/round_robin_fifo_distributor_if.sv
// Producer/consumer bus of the distributor; directions are named from the DUT side.
interface round_robin_fifo_distributor_if #(
  parameter int WIDTH = 8
);
  import round_robin_fifo_distributor_pkg::*;

  logic              i_wen;
  logic [WIDTH-1:0]  i_din;
  logic              o_in_ready;
  logic [NUM_CH-1:0] i_ren;
  logic [WIDTH-1:0]  o_a;
  logic [WIDTH-1:0]  o_b;
  logic [WIDTH-1:0]  o_c;
  logic [WIDTH-1:0]  o_d;
  logic [NUM_CH-1:0] o_valid;
  logic [NUM_CH-1:0] o_empty;
  logic              o_ovf;
  logic [NUM_CH-1:0] o_udf;

  modport master (
    output i_wen, i_din, i_ren,
    input  o_in_ready, o_a, o_b, o_c, o_d, o_valid, o_empty, o_ovf, o_udf
  );

  modport slave (
    input  i_wen, i_din, i_ren,
    output o_in_ready, o_a, o_b, o_c, o_d, o_valid, o_empty, o_ovf, o_udf
  );

endinterface

// File: rtl/round_robin_fifo_distributor_dist_fifo_chan.sv
// One per-channel FIFO with registered read data, read-success and underflow pulses.
module dist_fifo_chan
  import round_robin_fifo_distributor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wen,
  input  logic             i_ren,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic             o_udf,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_udf;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_wen && !o_full;
  assign w_rd    = i_ren && !o_empty;

  // Storage is not reset; a same-address read sees the old word.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_valid <= w_rd;
      r_udf   <= i_ren && o_empty;
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) begin
        r_dout <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_dout;
  assign o_valid = r_valid;
  assign o_udf   = r_udf;

endmodule

// File: rtl/round_robin_fifo_distributor.sv
// Round-robin write demux of one byte stream into four channel FIFOs a..d.
module round_robin_fifo_distributor
  import round_robin_fifo_distributor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic                           i_clk,
  input logic                           i_rst,
  round_robin_fifo_distributor_if.slave bus
);

  logic [CH_W-1:0]   r_tgt;
  logic              r_ovf;
  logic              w_in_ready;
  logic              w_accept;
  logic [NUM_CH-1:0] w_ch_wen;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_udf;
  logic [WIDTH-1:0]  w_dout [NUM_CH];

  // Ready looks only at the target's fill level; a same-cycle read does not free a slot.
  assign w_in_ready = !w_full[r_tgt];
  assign w_accept   = bus.i_wen && w_in_ready;

  always_comb begin
    w_ch_wen        = '0;
    w_ch_wen[r_tgt] = w_accept;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dist_fifo_chan #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_wen   (w_ch_wen[g]),
      .i_ren   (bus.i_ren[g]),
      .i_din   (bus.i_din),
      .o_dout  (w_dout[g]),
      .o_valid (w_valid[g]),
      .o_udf   (w_udf[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tgt <= CH_A;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= bus.i_wen && !w_in_ready;
      if (w_accept) r_tgt <= r_tgt + 1'b1;
    end
  end

  assign bus.o_in_ready = w_in_ready;
  assign bus.o_a        = w_dout[CH_A];
  assign bus.o_b        = w_dout[CH_B];
  assign bus.o_c        = w_dout[CH_C];
  assign bus.o_d        = w_dout[CH_D];
  assign bus.o_valid    = w_valid;
  assign bus.o_empty    = w_empty;
  assign bus.o_ovf      = r_ovf;
  assign bus.o_udf      = w_udf;

endmodule

// File: tb/tb_round_robin_fifo_distributor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_round_robin_fifo_distributor;
  import round_robin_fifo_distributor_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  round_robin_fifo_distributor_if #(.WIDTH(WIDTH)) bus ();

  round_robin_fifo_distributor #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one queue per channel and a round-robin target index.
  logic [WIDTH-1:0] q [NUM_CH][$];
  int               m_tgt;
  logic [WIDTH-1:0] exp_out [NUM_CH];
  logic [3:0]       exp_valid, exp_udf, exp_empty;
  logic             exp_ovf, exp_ready;
  logic             obs_ready;
  logic [3:0]       obs_empty;

  // Applies one cycle of stimulus, samples combinational outputs before the edge,
  // advances the model, and returns 1 ns after the edge.
  task automatic drive(input logic r, input logic w, input logic [WIDTH-1:0] d, input logic [3:0] rd);
    rst = r; bus.i_wen = w; bus.i_din = d; bus.i_ren = rd;
    #1;
    obs_ready = bus.o_in_ready;
    obs_empty = bus.o_empty;
    exp_ready = (q[m_tgt].size() != DEPTH);
    for (int i = 0; i < NUM_CH; i++) exp_empty[i] = (q[i].size() == 0);
    exp_valid = '0;
    exp_udf   = '0;
    exp_ovf   = 1'b0;
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        q[i].delete();
        exp_out[i] = '0;
      end
      m_tgt = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd[i]) begin
          if (q[i].size() > 0) begin
            exp_out[i]   = q[i].pop_front();
            exp_valid[i] = 1'b1;
          end else begin
            exp_udf[i] = 1'b1;
          end
        end
      end
      exp_ovf = w && !exp_ready;
      if (w && exp_ready) begin
        q[m_tgt].push_back(d);
        m_tgt = (m_tgt + 1) % NUM_CH;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    n_cmp++;
    if ({bus.o_a, bus.o_b, bus.o_c, bus.o_d} !== 32'h0) begin
      n_err++; $display("FAIL reset_data got %h want 00000000", {bus.o_a, bus.o_b, bus.o_c, bus.o_d});
    end
    n_cmp++;
    if ({bus.o_valid, bus.o_udf, bus.o_ovf} !== 9'h0) begin
      n_err++; $display("FAIL reset_flags got valid=%b udf=%b ovf=%b want 0", bus.o_valid, bus.o_udf, bus.o_ovf);
    end
    n_cmp++;
    if (bus.o_empty !== 4'b1111 || bus.o_in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_status got empty=%b ready=%b want 1111/1", bus.o_empty, bus.o_in_ready);
    end
  endtask

  task automatic test_fill_pattern();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, WIDTH'(k), '0);
      n_cmp++;
      if (obs_ready !== 1'b1) begin
        n_err++; $display("FAIL fill_ready word %0d got %b want 1", k, obs_ready);
      end
    end
    n_cmp++;
    if (bus.o_empty !== 4'b0000) begin
      n_err++; $display("FAIL fill_empty got %b want 0000", bus.o_empty);
    end
  endtask

  task automatic test_drain();
    drive(1'b0, 1'b0, '0, 4'b1111);
    n_cmp++;
    if ({bus.o_a, bus.o_b, bus.o_c, bus.o_d, bus.o_valid} !== {32'h01020304, 4'b1111}) begin
      n_err++; $display("FAIL drain1 got %h valid=%b want 01020304 1111", {bus.o_a, bus.o_b, bus.o_c, bus.o_d}, bus.o_valid);
    end
    drive(1'b0, 1'b0, '0, 4'b1111);
    n_cmp++;
    if ({bus.o_a, bus.o_b, bus.o_c, bus.o_d, bus.o_valid} !== {32'h05060708, 4'b1111}) begin
      n_err++; $display("FAIL drain2 got %h valid=%b want 05060708 1111", {bus.o_a, bus.o_b, bus.o_c, bus.o_d}, bus.o_valid);
    end
    drive(1'b0, 1'b0, '0, '0);
    n_cmp++;
    if (bus.o_empty !== 4'b1111 || bus.o_valid !== 4'b0000) begin
      n_err++; $display("FAIL drain_empty got empty=%b valid=%b want 1111/0000", bus.o_empty, bus.o_valid);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 1'b1, WIDTH'(8'h10 + k), '0);
      n_cmp++;
      if (obs_ready !== 1'b1 || bus.o_ovf !== 1'b0) begin
        n_err++; $display("FAIL ovf_fill word %0d got ready=%b ovf=%b want 1/0", k, obs_ready, bus.o_ovf);
      end
    end
    drive(1'b0, 1'b1, 8'h30, '0);
    n_cmp++;
    if (obs_ready !== 1'b0 || bus.o_ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_refuse got ready=%b ovf=%b want 0/1", obs_ready, bus.o_ovf);
    end
    drive(1'b0, 1'b0, '0, 4'b0001);
    n_cmp++;
    if (bus.o_a !== 8'h10 || bus.o_valid !== 4'b0001 || bus.o_ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_pop got a=%h valid=%b ovf=%b want 10/0001/0", bus.o_a, bus.o_valid, bus.o_ovf);
    end
    drive(1'b0, 1'b1, 8'h30, '0);
    n_cmp++;
    if (obs_ready !== 1'b1 || bus.o_ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_retry got ready=%b ovf=%b want 1/0", obs_ready, bus.o_ovf);
    end
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b0, '0, 4'b1111);
      n_cmp++;
      if ({bus.o_a, bus.o_b, bus.o_c, bus.o_d} !== {exp_out[0], exp_out[1], exp_out[2], exp_out[3]} ||
          bus.o_valid !== exp_valid) begin
        n_err++; $display("FAIL ovf_drain step %0d got %h/%b want %h/%b", k, {bus.o_a, bus.o_b, bus.o_c, bus.o_d},
                          bus.o_valid, {exp_out[0], exp_out[1], exp_out[2], exp_out[3]}, exp_valid);
      end
    end
    n_cmp++;
    if ({bus.o_a, bus.o_b, bus.o_c, bus.o_d} !== 32'h302D2E2F) begin
      n_err++; $display("FAIL ovf_last got %h want 302D2E2F", {bus.o_a, bus.o_b, bus.o_c, bus.o_d});
    end
    // Retry moved the target to b, so the next word must come out of b.
    drive(1'b0, 1'b1, 8'h99, '0);
    drive(1'b0, 1'b0, '0, 4'b0010);
    n_cmp++;
    if (bus.o_b !== 8'h99 || bus.o_valid !== 4'b0010) begin
      n_err++; $display("FAIL ovf_tgt got b=%h valid=%b want 99/0010", bus.o_b, bus.o_valid);
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b0, '0, 4'b0100);
    n_cmp++;
    if (bus.o_udf !== 4'b0100 || bus.o_valid !== 4'b0000 || bus.o_c !== 8'h2E) begin
      n_err++; $display("FAIL udf got udf=%b valid=%b c=%h want 0100/0000/2e", bus.o_udf, bus.o_valid, bus.o_c);
    end
    drive(1'b0, 1'b0, '0, '0);
    n_cmp++;
    if (bus.o_udf !== 4'b0000) begin
      n_err++; $display("FAIL udf_clear got %b want 0000", bus.o_udf);
    end
  endtask

  task automatic test_rw_same();
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 8'h55, '0);
    drive(1'b0, 1'b1, 8'h01, '0);
    drive(1'b0, 1'b1, 8'h02, '0);
    drive(1'b0, 1'b1, 8'h03, '0);
    drive(1'b0, 1'b1, 8'hAA, 4'b0001);
    n_cmp++;
    if (bus.o_a !== 8'h55 || bus.o_valid !== 4'b0001 || bus.o_udf !== 4'b0000 || obs_ready !== 1'b1) begin
      n_err++; $display("FAIL rw_same got a=%h valid=%b udf=%b ready=%b want 55/0001/0000/1",
                        bus.o_a, bus.o_valid, bus.o_udf, obs_ready);
    end
    drive(1'b0, 1'b0, '0, 4'b0001);
    n_cmp++;
    if (obs_empty[0] !== 1'b0 || bus.o_a !== 8'hAA || bus.o_valid !== 4'b0001) begin
      n_err++; $display("FAIL rw_next got empty0=%b a=%h valid=%b want 0/aa/0001", obs_empty[0], bus.o_a, bus.o_valid);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 1'b1, 8'h61, '0);
    drive(1'b0, 1'b1, 8'h62, '0);
    drive(1'b0, 1'b1, 8'h63, '0);
    drive(1'b1, 1'b1, 8'h64, 4'b1111);
    n_cmp++;
    if ({bus.o_a, bus.o_b, bus.o_c, bus.o_d} !== 32'h0 || {bus.o_valid, bus.o_udf, bus.o_ovf} !== 9'h0) begin
      n_err++; $display("FAIL midrst_out got %h flags=%b want 0", {bus.o_a, bus.o_b, bus.o_c, bus.o_d},
                        {bus.o_valid, bus.o_udf, bus.o_ovf});
    end
    drive(1'b0, 1'b1, 8'h77, '0);
    n_cmp++;
    if (obs_empty !== 4'b1111) begin
      n_err++; $display("FAIL midrst_empty got %b want 1111", obs_empty);
    end
    drive(1'b0, 1'b0, '0, 4'b1111);
    n_cmp++;
    if (bus.o_a !== 8'h77 || bus.o_valid !== 4'b0001 || bus.o_udf !== 4'b1110) begin
      n_err++; $display("FAIL midrst_land got a=%h valid=%b udf=%b want 77/0001/1110", bus.o_a, bus.o_valid, bus.o_udf);
    end
  endtask

  task automatic test_random();
    logic             r, w;
    logic [WIDTH-1:0] d;
    logic [3:0]       rd;
    drive(1'b1, 1'b0, '0, '0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      r  = ($urandom_range(0, 99) == 0);
      w  = ($urandom_range(0, 3) != 0);
      d  = WIDTH'($urandom);
      rd = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if (cyc >= 300) rd = 4'($urandom_range(0, 15));
      drive(r, w, d, rd);
      n_cmp++;
      if (obs_ready !== exp_ready || obs_empty !== exp_empty) begin
        n_err++; $display("FAIL rand_status cyc %0d got ready=%b empty=%b want %b/%b", cyc, obs_ready, obs_empty,
                          exp_ready, exp_empty);
      end
      n_cmp++;
      if ({bus.o_a, bus.o_b, bus.o_c, bus.o_d} !== {exp_out[0], exp_out[1], exp_out[2], exp_out[3]}) begin
        n_err++; $display("FAIL rand_data cyc %0d got %h want %h", cyc, {bus.o_a, bus.o_b, bus.o_c, bus.o_d},
                          {exp_out[0], exp_out[1], exp_out[2], exp_out[3]});
      end
      n_cmp++;
      if (bus.o_valid !== exp_valid || bus.o_udf !== exp_udf || bus.o_ovf !== exp_ovf) begin
        n_err++; $display("FAIL rand_flags cyc %0d got valid=%b udf=%b ovf=%b want %b/%b/%b", cyc, bus.o_valid,
                          bus.o_udf, bus.o_ovf, exp_valid, exp_udf, exp_ovf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.i_wen = 1'b0; bus.i_din = '0; bus.i_ren = '0;
    m_tgt = 0;
    for (int i = 0; i < NUM_CH; i++) exp_out[i] = '0;
    test_reset();
    test_fill_pattern();
    test_drain();
    test_overflow();
    test_underflow();
    test_rw_same();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
